// File: rtl/color_dither_pkg.sv
// Shared definitions for the colour-depth reducer: mode encodings and a
// width-parametrised bit-reverse used to spread the temporal dither phase.
package color_dither_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC    = 2'd0,
    MODE_ROUND    = 2'd1,
    MODE_TEMPORAL = 2'd2,
    MODE_SIGDELTA = 2'd3
  } mode_t;

  localparam int unsigned BR_MAXW = 16;

  // Reverses the low w bits of v; bits at and above w return as zero.
  function automatic logic [BR_MAXW-1:0] bitrev(input logic [BR_MAXW-1:0] v,
                                                input int unsigned w);
    logic [BR_MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BR_MAXW; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/color_dither_cvt_if.sv
// Pixel bus into and out of the colour-depth reducer.
interface color_dither_cvt_if #(
  parameter int IW  = 6,
  parameter int OW  = 4,
  parameter int NCH = 3
);
  logic                vld_i;
  logic                sof_i;
  logic [1:0]          mode_i;
  logic [NCH*IW-1:0]   pix_i;
  logic                vld_o;
  logic [NCH*OW-1:0]   pix_o;

  modport master (output vld_i, sof_i, mode_i, pix_i, input  vld_o, pix_o);
  modport slave  (input  vld_i, sof_i, mode_i, pix_i, output vld_o, pix_o);
endinterface

// File: rtl/color_dither_chan.sv
// One colour channel: picks the increment bit for the active mode, adds it
// to the kept MSBs with saturation, and keeps the sigma-delta residue.
module color_dither_chan
  import color_dither_pkg::*;
#(
  parameter int IW = 6,
  parameter int OW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             sof,
  input  logic [1:0]       mode,
  input  logic [IW-OW-1:0] ph,
  input  logic [IW-1:0]    pix,
  output logic [OW-1:0]    q
);
  localparam int DW = IW - OW;

  logic [OW-1:0] hi, q_nxt;
  logic [DW-1:0] frac, acc, acc_eff, ph_eff, ph_rev;
  logic [DW:0]   sum;
  logic          inc;

  assign hi      = pix[IW-1:DW];
  assign frac    = pix[DW-1:0];
  // A start-of-frame pixel is processed as if all dither state were zero.
  assign ph_eff  = sof ? '0 : ph;
  assign acc_eff = sof ? '0 : acc;
  assign ph_rev  = DW'(bitrev(BR_MAXW'(ph_eff), DW));
  assign sum     = {1'b0, acc_eff} + {1'b0, frac};

  always_comb begin
    inc = 1'b0;
    case (mode)
      MODE_TRUNC:    inc = 1'b0;
      MODE_ROUND:    inc = frac[DW-1];
      MODE_TEMPORAL: inc = (frac > ph_rev);
      MODE_SIGDELTA: inc = sum[DW];
      default:       inc = 1'b0;
    endcase
  end

  assign q_nxt = (&hi) ? '1 : hi + OW'(inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
    end else if (vld) begin
      q <= q_nxt;
      // Residue still advances while saturated, so full-scale error is dropped.
      if (mode == MODE_SIGDELTA) acc <= sum[DW-1:0];
      else if (sof)              acc <= '0;
    end
  end

endmodule

// File: rtl/color_dither_cvt.sv
// Colour-depth reducer top: shared dither phase counter, output valid and
// per-channel packing around NCH channel slices.
module color_dither_cvt
  import color_dither_pkg::*;
#(
  parameter int IW  = 6,
  parameter int OW  = 4,
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              rst,
  color_dither_cvt_if.slave bus
);
  localparam int DW = IW - OW;

  logic [DW-1:0]              ph;
  logic                       vld_q;
  logic                       sof_eff;
  logic [NCH-1:0][OW-1:0]     pix_q;

  assign sof_eff = bus.vld_i & bus.sof_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph    <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.vld_i;
      // The sof pixel consumes phase 0, so the next pixel sees phase 1.
      if (bus.vld_i) ph <= sof_eff ? DW'(1) : ph + DW'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    color_dither_chan #(.IW(IW), .OW(OW)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .vld  (bus.vld_i),
      .sof  (sof_eff),
      .mode (bus.mode_i),
      .ph   (ph),
      .pix  (bus.pix_i[c*IW +: IW]),
      .q    (pix_q[c])
    );
  end

  assign bus.vld_o = vld_q;
  assign bus.pix_o = pix_q;

endmodule

// File: tb/tb_color_dither_cvt.sv
// Directed bench for color_dither_cvt at IW=6, OW=4, NCH=3.
module tb_color_dither_cvt;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  color_dither_cvt_if #(.IW(6), .OW(4), .NCH(3)) bus ();

  color_dither_cvt #(.IW(6), .OW(4), .NCH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic sof, input logic [1:0] mode,
                       input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2);
    bus.vld_i  = vld;
    bus.sof_i  = sof;
    bus.mode_i = mode;
    bus.pix_i  = {c2, c1, c0};
    @(posedge clk);
    #1;
  endtask

  // One valid pixel on channel 0 (others zero), then check channel 0.
  task automatic px(input string tag, input logic sof, input logic [1:0] mode,
                    input logic [5:0] c0, input logic [3:0] exp0);
    drive(1'b1, sof, mode, c0, 6'd0, 6'd0);
    chk({tag, "_vld"}, 32'(bus.vld_o), 32'd1);
    chk(tag, 32'(bus.pix_o[3:0]), 32'(exp0));
  endtask

  initial begin
    logic [3:0] t1 [4];
    logic [3:0] t3 [4];
    logic [3:0] sd [8];
    t1 = '{4'd3, 4'd2, 4'd2, 4'd2};
    t3 = '{4'd3, 4'd3, 4'd3, 4'd2};
    sd = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd2, 4'd2, 4'd2, 4'd3};

    // Reset with a pixel presented: it must be discarded.
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 6'h27, 6'd0, 6'd0);
    chk("rst_vld", 32'(bus.vld_o), 32'd0);
    chk("rst_pix", 32'(bus.pix_o), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 6'h27, 6'd0, 6'd0);
    chk("lat_vld", 32'(bus.vld_o), 32'd1);
    chk("lat_ch0", 32'(bus.pix_o[3:0]), 32'd9);

    // ROUND, with all three channels exercised on the first pixel.
    drive(1'b1, 1'b0, 2'd1, 6'b000110, 6'b101011, 6'b000001);
    chk("round_all", 32'(bus.pix_o), 32'h0B2);
    px("round_b", 1'b0, 2'd1, 6'b000101, 4'd1);
    px("round_sat", 1'b0, 2'd1, 6'b111110, 4'd15);

    // TEMPORAL, frac 1 then frac 3, each frame started by sof.
    for (int i = 0; i < 4; i++) px("temp_f1", i == 0, 2'd2, 6'b001001, t1[i]);
    for (int i = 0; i < 4; i++) px("temp_f3", i == 0, 2'd2, 6'b001011, t3[i]);

    // SIGDELTA back-to-back, then with idle gaps between pixels.
    for (int i = 0; i < 8; i++) px("sd", i == 0, 2'd3, 6'b001001, sd[i]);
    for (int i = 0; i < 8; i++) begin
      px("sd_gap", i == 0, 2'd3, 6'b001001, sd[i]);
      drive(1'b0, 1'b0, 2'd3, 6'b111111, 6'd0, 6'd0);
      chk("gap_vld", 32'(bus.vld_o), 32'd0);
      chk("gap_hold", 32'(bus.pix_o[3:0]), 32'(sd[i]));
    end

    // Mid-frame sof in TEMPORAL, then sof without vld is ignored.
    px("mid_a", 1'b1, 2'd2, 6'b001001, 4'd3);
    px("mid_b", 1'b0, 2'd2, 6'b001001, 4'd2);
    px("mid_sof", 1'b1, 2'd2, 6'b001001, 4'd3);
    drive(1'b0, 1'b1, 2'd2, 6'b001001, 6'd0, 6'd0);
    chk("idle_sof_vld", 32'(bus.vld_o), 32'd0);
    chk("idle_sof_hold", 32'(bus.pix_o[3:0]), 32'd3);
    px("after_idle_sof", 1'b0, 2'd2, 6'b001001, 4'd2);

    // Saturation in every mode on every channel.
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, k == 0, 2'(m), 6'h3F, 6'h3F, 6'h3F);
        chk("sat", 32'(bus.pix_o), 32'hFFF);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
